// File: rtl/seq_divider_pkg.sv
// Shared types for the FFT arithmetic blocks: divider FSM states and counter sizing.
package fft_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must hold N-1; keep at least one bit for tiny N.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
interface seq_divider_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_step.sv
// One combinational restoring-division step on the upper remainder half.
module div_step #(
    parameter int N = 16
) (
    input  logic [N-1:0] rem_hi,
    input  logic [N-1:0] divisor,
    input  logic         shift_in,
    output logic [N-1:0] rem_nx,
    output logic         q_bit
);
    logic [N:0] trial;

    // rem_hi < divisor always holds, so an N+1-bit difference is enough and
    // its MSB is the borrow.
    assign trial  = {rem_hi, shift_in} - {1'b0, divisor};
    assign q_bit  = ~trial[N];
    assign rem_nx = q_bit ? trial[N-1:0] : {rem_hi[N-2:0], shift_in};
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider, one operation in flight.
// Define DIV_SIGNED_EN for two's-complement operands (truncating toward zero).
module seq_divider
    import fft_arith_pkg::*;
#(
    parameter int N = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int CW = cnt_w(N);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [2*N-1:0]  acc;
    logic [N-1:0]    dvs;
    logic [N-1:0]    q_r, r_r;
    logic            dbz_r;
    logic            div_zero;
    logic [N-1:0]    a_mag, b_mag;
    logic [N-1:0]    step_rem;
    logic            step_q;
    logic [N-1:0]    q_raw, q_fin, r_fin;

    assign div_zero = (bus.divisor == '0);

    div_step #(.N(N)) u_step (
        .rem_hi   (acc[2*N-1:N]),
        .divisor  (dvs),
        .shift_in (acc[N-1]),
        .rem_nx   (step_rem),
        .q_bit    (step_q)
    );

    assign q_raw = {acc[N-2:0], step_q};

`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r;

    assign a_mag = bus.dividend[N-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    assign b_mag = bus.divisor[N-1]  ? (~bus.divisor  + 1'b1) : bus.divisor;
    // Fix-up rides on the final step so latency matches the unsigned build.
    assign q_fin = neg_q ? (~q_raw + 1'b1) : q_raw;
    assign r_fin = neg_r ? (~step_rem + 1'b1) : step_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            neg_q <= bus.dividend[N-1] ^ bus.divisor[N-1];
            neg_r <= bus.dividend[N-1];
        end
    end
`else
    assign a_mag = bus.dividend;
    assign b_mag = bus.divisor;
    assign q_fin = q_raw;
    assign r_fin = step_rem;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nx = div_zero ? DONE : CALC;
            end
            CALC: begin
                if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            q_r   <= '0;
            r_r   <= '0;
            dbz_r <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            acc <= {{N{1'b0}}, a_mag};
            dvs <= b_mag;
            cnt <= CW'(N-1);
            if (div_zero) begin
                q_r   <= '1;
                r_r   <= bus.dividend;
                dbz_r <= 1'b1;
            end
        end else if (state == CALC) begin
            acc <= {step_rem, q_raw};
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                q_r   <= q_fin;
                r_r   <= r_fin;
                dbz_r <= 1'b0;
            end
        end
    end

    assign bus.quotient    = q_r;
    assign bus.remainder   = r_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks for seq_divider (N=16); follows DIV_SIGNED_EN like the RTL.
module tb_seq_divider;
    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    seq_divider_if #(.N(16)) bus ();

    seq_divider #(.N(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r, output logic dbz);
        if (b == 16'd0) begin
            q = 16'hFFFF; r = a; dbz = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            int sa, sb;
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = 16'(sa / sb);
            r  = 16'(sa % sb);
`else
            q  = a / b;
            r  = a % b;
`endif
            dbz = 1'b0;
        end
    endtask

    // lat counts edges from presenting operands, accept edge included.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int hold, input logic [15:0] eq, input logic [15:0] er,
                          input logic edbz, input int elat);
        int lat;
        logic [15:0] q0, r0;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_q"}, 32'(bus.quotient), 32'(eq));
        check({tag, "_r"}, 32'(bus.remainder), 32'(er));
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(edbz));
        q0 = bus.quotient;
        r0 = bus.remainder;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;  // must be ignored while DONE
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            check({tag, "_hold_vld"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_rdy"}, 32'(bus.in_ready), 32'd0);
            check({tag, "_hold_q"}, 32'(bus.quotient), 32'(q0));
            check({tag, "_hold_r"}, 32'(bus.remainder), 32'(r0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        if (hold > 0) begin
            check({tag, "_rel_vld"}, 32'(bus.out_valid), 32'd0);
            check({tag, "_rel_q"}, 32'(bus.quotient), 32'(eq));
        end
    endtask

    initial begin
        logic [15:0] a, b, eq, er;
        logic        edbz;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_q", 32'(bus.quotient), 32'd0);
        check("rst_r", 32'(bus.remainder), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("t1", 16'd100, 16'd7, 0, 16'd14, 16'd2, 1'b0, 17);
        run_op("t2a", 16'hFFFF, 16'd1, 0, 16'hFFFF, 16'd0, 1'b0, 17);
        run_op("t2b", 16'd5, 16'd9, 0, 16'd0, 16'd5, 1'b0, 17);
        run_op("t3", 16'd1234, 16'd0, 0, 16'hFFFF, 16'd1234, 1'b1, 1);
        run_op("t4", 16'd1000, 16'd10, 5, 16'd100, 16'd0, 1'b0, 17);
        run_op("t4b", 16'd77, 16'd5, 0, 16'd15, 16'd2, 1'b0, 17);

        // Abort mid-calculation with an asynchronous reset.
        bus.in_valid = 1'b1;
        bus.dividend = 16'd50000;
        bus.divisor  = 16'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_in_ready", 32'(bus.in_ready), 32'd1);
        check("t5_q", 32'(bus.quotient), 32'd0);
        check("t5_r", 32'(bus.remainder), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("t5b", 16'd9, 16'd2, 0, 16'd4, 16'd1, 1'b0, 17);

`ifdef DIV_SIGNED_EN
        run_op("t6a", 16'hFF9C, 16'd7, 0, 16'hFFF2, 16'hFFFE, 1'b0, 17);
        run_op("t6b", 16'h8000, 16'hFFFF, 0, 16'h8000, 16'd0, 1'b0, 17);
        run_op("t6c", 16'hFF9C, 16'd0, 0, 16'hFFFF, 16'hFF9C, 1'b1, 1);
`endif

        for (int k = 0; k < 2000; k++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 16'd0 :
                ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 20)) : 16'($urandom);
            model(a, b, eq, er, edbz);
            run_op("rnd", a, b, 0, eq, er, edbz, (b == 16'd0) ? 1 : 17);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
